// File: rtl/sevseg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with frame-boundary shadow
// updates and a blanking interval per slot. Optional PWM dimming: SEVSEG_PWM_EN.

module sevseg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    update,
  input  logic                    enable,
`ifdef SEVSEG_PWM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, ON = 2'd2} state_t;

  state_t                  state_r, state_s;
  logic [IW-1:0]           idx_r, idx_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic                    wrap_r, wrap_s;
  logic                    apply_s;
  logic                    pwm_ok_s;
  logic [4*NUM_DIGITS-1:0] stage_data_r, shadow_data_r;
  logic [NUM_DIGITS-1:0]   stage_dp_r, shadow_dp_r;
  logic [NUM_DIGITS-1:0]   stage_en_r, shadow_en_r;
  logic                    pending_r;
  logic [3:0]              nibble_s;
  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  logic                    dp_s;
  logic                    fd_s;

  // Active-high gfedcba pattern for a hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      4'hF: seg_decode = 7'h71;
      default: seg_decode = 7'h00;
    endcase
  endfunction

`ifdef SEVSEG_PWM_EN
  logic [3:0] pwm_r, pwm_s;

  // PWM count restarts on ON entry and runs only while ON persists.
  always_comb begin
    if (state_r == ON && state_s == ON) begin
      pwm_s = pwm_r + 4'd1;
    end else begin
      pwm_s = 4'd0;
    end
    pwm_ok_s = (pwm_r <= brightness);
  end

  // PWM counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_r <= 4'd0;
    end else begin
      pwm_r <= pwm_s;
    end
  end
`else
  assign pwm_ok_s = 1'b1;
`endif

  // Scan state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= {IW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      wrap_r  <= wrap_s;
    end
  end

  // Next-state: slot sequencing, digit index advance and frame wrap.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    wrap_s  = 1'b0;
    if (!enable) begin
      state_s = IDLE;
      idx_s   = {IW{1'b0}};
      cnt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_s = BLANK;
          idx_s   = {IW{1'b0}};
          cnt_s   = {CW{1'b0}};
        end
        BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_s = ON;
            cnt_s   = {CW{1'b0}};
          end else begin
            cnt_s = cnt_r + CW'(1'b1);
          end
        end
        ON: begin
          if (cnt_r == ON_LAST) begin
            state_s = BLANK;
            cnt_s   = {CW{1'b0}};
            if (idx_r == LAST_IDX) begin
              idx_s  = {IW{1'b0}};
              wrap_s = 1'b1;
            end else begin
              idx_s = idx_r + IW'(1'b1);
            end
          end else begin
            cnt_s = cnt_r + CW'(1'b1);
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = {IW{1'b0}};
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Staged values move to shadow only while idle or on the frame wrap.
  assign apply_s  = pending_r && (state_r == IDLE || wrap_s);
  assign nibble_s = shadow_data_r[{idx_r, 2'b00} +: 4];

  // Staging and shadow registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_data_r  <= {(4*NUM_DIGITS){1'b0}};
      stage_dp_r    <= {NUM_DIGITS{1'b0}};
      stage_en_r    <= {NUM_DIGITS{1'b0}};
      shadow_data_r <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r   <= {NUM_DIGITS{1'b0}};
      shadow_en_r   <= {NUM_DIGITS{1'b0}};
      pending_r     <= 1'b0;
    end else begin
      if (update) begin
        stage_data_r <= digit_data;
        stage_dp_r   <= dp_in;
        stage_en_r   <= digit_en;
      end
      if (apply_s) begin
        shadow_data_r <= stage_data_r;
        shadow_dp_r   <= stage_dp_r;
        shadow_en_r   <= stage_en_r;
      end
      if (update) begin
        pending_r <= 1'b1;
      end else if (apply_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Output decode from the current state; enable low forces everything off.
  always_comb begin
    an_s  = {NUM_DIGITS{1'b1}};
    seg_s = 7'h7F;
    dp_s  = 1'b1;
    fd_s  = wrap_r;
    if (enable && (state_r == BLANK || state_r == ON)) begin
      seg_s = ~seg_decode(nibble_s);
      dp_s  = ~shadow_dp_r[idx_r];
      if (state_r == ON) begin
        an_s[idx_r] = ~(shadow_en_r[idx_r] & pwm_ok_s);
      end else begin
        an_s = {NUM_DIGITS{1'b1}};
      end
    end else begin
      an_s = {NUM_DIGITS{1'b1}};
    end
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      an         <= {NUM_DIGITS{1'b1}};
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_s;
      seg        <= seg_s;
      dp         <= dp_s;
      frame_done <= fd_s;
    end
  end

  assign update_pending = pending_r;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Self-checking bench for sevseg_scan_driver (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2);
// the reference model tracks display position as a cycle count since enable.

module tb_sevseg_scan_driver;

  localparam int ND    = 4;
  localparam int PS    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * PS;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        update;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
`ifdef SEVSEG_PWM_EN
  logic [3:0]  brightness;
`endif
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic        update_pending;

  int errors = 0;
  int checks = 0;

  logic [6:0] pat [0:15];

  // Model state: running flag, position since enable, staging, shadow, pending
  bit          m_run;
  int          m_s;
  logic [15:0] m_stage_d, m_sh_d;
  logic [3:0]  m_stage_dp, m_sh_dp, m_stage_en, m_sh_en;
  bit          m_pending;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fd;

  sevseg_scan_driver #(
    .NUM_DIGITS  (ND),
    .PRESCALE    (PS),
    .BLANK_CYCLES(BC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .digit_data    (digit_data),
    .dp_in         (dp_in),
    .digit_en      (digit_en),
    .update        (update),
    .enable        (enable),
`ifdef SEVSEG_PWM_EN
    .brightness    (brightness),
`endif
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .frame_done    (frame_done),
    .update_pending(update_pending)
  );

  always #5 clock = ~clock;

  function automatic bit lit_now(input int on_cycle);
`ifdef SEVSEG_PWM_EN
    return ((on_cycle % 16) <= int'(brightness));
`else
    return (on_cycle >= 0);
`endif
  endfunction

  // Expected registered outputs come from the pre-edge model state.
  task automatic model_edge();
    int slot;
    int off;
    bit wrap;
    bit apply;
    logic [3:0] nib;
    if (reset) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
      m_run = 1'b0; m_s = 0; m_pending = 1'b0;
      m_stage_d = 16'h0; m_stage_dp = 4'h0; m_stage_en = 4'h0;
      m_sh_d = 16'h0; m_sh_dp = 4'h0; m_sh_en = 4'h0;
    end else begin
      exp_fd  = m_run && (m_s > 0) && ((m_s % FRAME) == 0);
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      if (enable && m_run) begin
        slot    = (m_s / PS) % ND;
        off     = m_s % PS;
        nib     = m_sh_d[slot*4 +: 4];
        exp_seg = ~pat[nib];
        exp_dp  = ~m_sh_dp[slot];
        if (off >= BC && m_sh_en[slot] && lit_now(off - BC)) exp_an[slot] = 1'b0;
      end
      wrap  = m_run && enable && (((m_s + 1) % FRAME) == 0);
      apply = m_pending && (!m_run || wrap);
      if (apply) begin
        m_sh_d = m_stage_d; m_sh_dp = m_stage_dp; m_sh_en = m_stage_en;
      end
      if (update) begin
        m_stage_d = digit_data; m_stage_dp = dp_in; m_stage_en = digit_en;
        m_pending = 1'b1;
      end else if (apply) begin
        m_pending = 1'b0;
      end
      m_s   = (enable && m_run) ? m_s + 1 : 0;
      m_run = enable;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    checks++;
    assert (an === exp_an) else begin
      errors++; $error("FAIL an: observed=%h expected=%h t=%0t", an, exp_an, $time);
    end
    checks++;
    assert (seg === exp_seg) else begin
      errors++; $error("FAIL seg: observed=%h expected=%h t=%0t", seg, exp_seg, $time);
    end
    checks++;
    assert (dp === exp_dp) else begin
      errors++; $error("FAIL dp: observed=%b expected=%b t=%0t", dp, exp_dp, $time);
    end
    checks++;
    assert (frame_done === exp_fd) else begin
      errors++; $error("FAIL frame_done: observed=%b expected=%b t=%0t", frame_done, exp_fd, $time);
    end
    checks++;
    assert (update_pending === m_pending) else begin
      errors++; $error("FAIL update_pending: observed=%b expected=%b t=%0t", update_pending, m_pending, $time);
    end
    update = 1'b0;
  endtask

  // Step until the next edge will leave position p within the frame.
  task automatic wait_pos(input int p);
    for (int i = 0; i < FRAME + 2 && !(m_run && (m_s % FRAME) == p); i++) tick();
  endtask

  initial begin
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    m_run = 1'b0; m_s = 0; m_pending = 1'b0;
    reset = 1'b1; enable = 1'b0; update = 1'b1;
    digit_data = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
`ifdef SEVSEG_PWM_EN
    brightness = 4'd15;
`endif
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();

    // Basic scan of 4321 with dp on digit 0
    digit_data = 16'h4321; digit_en = 4'hF; dp_in = 4'b0001; update = 1'b1;
    tick();
    repeat (2) tick();
    enable = 1'b1;
    repeat (70) tick();

    // Mid-frame update is held until the frame wraps
    wait_pos(12);
    digit_data = 16'hFFFF; update = 1'b1;
    tick();
    repeat (60) tick();

    // Disabled digits 1 and 3
    digit_data = 16'($urandom); digit_en = 4'b0101; update = 1'b1;
    tick();
    repeat (80) tick();

    // Drop enable during digit 2 ON, then re-enable
    wait_pos(20);
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    repeat (40) tick();

    // Update landing exactly on the frame-wrap edge with another pending
    digit_data = 16'($urandom); digit_en = 4'hF; dp_in = 4'($urandom); update = 1'b1;
    tick();
    wait_pos(FRAME - 1);
    digit_data = 16'($urandom); dp_in = 4'($urandom); update = 1'b1;
    tick();
    repeat (70) tick();

`ifdef SEVSEG_PWM_EN
    brightness = 4'd3;
    repeat (40) tick();
`endif

    // Randomized traffic including a mid-frame reset
    for (int i = 0; i < 400; i++) begin
      enable     = ($urandom_range(0, 59) != 0);
      update     = ($urandom_range(0, 11) == 0);
      reset      = (i == 200);
      digit_data = 16'($urandom);
      dp_in      = 4'($urandom);
      digit_en   = 4'($urandom);
`ifdef SEVSEG_PWM_EN
      brightness = 4'($urandom);
`endif
      tick();
    end
    reset = 1'b0; enable = 1'b1;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
Downstream stage of the seven-segment AXI4-Lite register slave. Consumes the slave's digit, decimal-point and enable registers and drives a common-anode multiplexed display. Uses tear-free frame-boundary updates and a blanking interval between digits to suppress ghosting. Instantiated beside the register slave inside the seven-segment IP.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
PRESCALE, 100000, clock cycles per digit slot, BLANK plus ON (>=2)
BLANK_CYCLES, 1000, cycles with all anodes off at the start of each slot (1 <= BLANK_CYCLES < PRESCALE)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
digit_data  in  4*NUM_DIGITS  hex nibble per digit; digit k is [4k+3:4k]
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
digit_en  in  NUM_DIGITS  per-digit enable, 1 = digit may light
update  in  1  one-cycle strobe that captures digit_data, dp_in and digit_en into staging
enable  in  1  global scan enable
an  out  NUM_DIGITS  anode selects, active-low
seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
dp  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse when the last digit slot ends
update_pending  out  1  staging holds values not yet applied

Behaviour:
- Reset (synchronous, active-high):
  - an = all 1, seg = 7'h7F, dp = 1, frame_done = 0, update_pending = 0.
  - Staging and shadow registers = 0; digit index = 0; slot counter = 0; state = IDLE.
  - Reset asserted mid-frame takes effect on the next clock edge.
- update: staging <= inputs on the same edge; update_pending <= 1.
- States: IDLE, BLANK, ON.
- IDLE:
  - Outputs off (an = all 1, seg = 7'h7F, dp = 1).
  - If update_pending, shadow <= staging one cycle later and update_pending clears.
  - enable = 1 → BLANK with index 0 and counter 0.
- BLANK:
  - an = all 1; seg and dp are driven from the decode of shadow[index].
  - Lasts exactly BLANK_CYCLES cycles, then → ON.
- ON:
  - an[index] = ~shadow_en[index]; all other anodes = 1.
  - Lasts PRESCALE - BLANK_CYCLES cycles.
  - Slot end: index increments. When index = NUM_DIGITS-1, index wraps to 0 and frame_done pulses on the first BLANK cycle of the new frame.
- Frame boundary (the wrap edge): if update_pending, shadow <= staging and update_pending <= 0.
  - If update arrives on that same edge, shadow takes the pre-update staging value, staging takes the new value, and update_pending stays 1.
- enable = 0 in any state → IDLE on the next edge with outputs off. Index, counter and PWM count reset; update_pending is preserved.
- Decode, active-high pattern gfedcba before inversion:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - seg = ~pattern; dp = ~shadow_dp[index].
- All outputs are registered. Latency from a slot-counter transition to the anode change is 1 cycle.
- Frame period = NUM_DIGITS*PRESCALE cycles.

Optional Feature:
SEVSEG_PWM_EN
- When defined:
  - Adds input port brightness (4 bits).
  - A 4-bit counter restarts at 0 on entry to ON and increments each ON cycle, wrapping at 16.
  - an[index] is low only while shadow_en[index] = 1 and counter <= brightness. brightness = 15 gives full on-time.
  - brightness is sampled directly, with no shadowing.
- When undefined: the brightness port is absent and the anode is low for the whole ON phase.

Test Plan:
(All scenarios use NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.)
1. Reset held 3 cycles, then released with enable=0 → an=4'hF, seg=7'h7F, dp=1, frame_done=0, update_pending=0 for 20 cycles.
2. digit_data=16'h4321, digit_en=4'hF, dp_in=4'b0001, update pulse, then enable=1 →
   - an sequence 1110, 1101, 1011, 0111, each low for 6 cycles with 2 all-high cycles between slots.
   - seg = 7'h79, 7'h24, 7'h30, 7'h19; dp = 0 only during digit0.
   - frame_done pulses every 32 cycles.
3. Mid-frame update with digit_data=16'hFFFF → the remainder of the frame shows 4321 and update_pending=1. Next frame shows seg=7'h0E on every digit and update_pending=0.
4. digit_en=4'b0101 → an[1] and an[3] are never low; an[0] and an[2] follow the normal timing.
5. enable dropped during digit2 ON → next cycle an=4'hF, seg=7'h7F. Re-enable → 2 BLANK cycles, then digit0 is driven.
6. update asserted exactly on the frame-wrap edge → the new frame shows the old staging value, update_pending stays 1, and the new value is applied at the following wrap.
   - With SEVSEG_PWM_EN and brightness=3: an low for 4 of the 6 ON cycles per slot.
